mux_rr_arbiter: RTL and testbench

//   Shares one 2:1 data mux (and its single output channel) between two requesters A and B.

---
 rtl/mux_rr_arbiter_pkg.sv | 16 +
 rtl/mux_rr_arbiter_mux.sv | 16 +
 rtl/mux_rr_arbiter.sv | 125 ++++++++++++
 tb/tb_mux_rr_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types for the round-robin mux arbiter.
// Owner states and output source encoding.
package mux_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } arb_state_t;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_t;

endpackage

// File: rtl/mux_rr_arbiter_mux.sv
// WIDTH-bit 2:1 data mux selected by source.
// Feeds the arbiter's output register.
module arb_data_mux
  import mux_rr_arbiter_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  src_t             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = (sel == SRC_B) ? b : a;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Two-requester round-robin arbiter with bounded burst and registered output.
// Define MUX_RR_ARBITER_STATS_EN to enable saturating transfer counters.
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int BURST = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;

  arb_state_t       state_q, state_d;
  logic [BW-1:0]    burst_q, burst_d;
  src_t             last_q;
  src_t             sel;
  logic             load;
  logic             burst_max;
  logic             gnt_a, gnt_b;
  logic [WIDTH-1:0] mux_y;

  assign load      = !out_valid || out_ready;
  assign burst_max = (burst_q == BW'(BURST - 1));

  always_comb begin
    gnt_a   = 1'b0;
    gnt_b   = 1'b0;
    state_d = state_q;
    burst_d = burst_q;
    if (load && !rst) begin
      unique case (state_q)
        OWN_A: begin
          if (a_valid && (!b_valid || !burst_max)) gnt_a = 1'b1;
          else if (b_valid)                        gnt_b = 1'b1;
          burst_d = (gnt_a && b_valid) ? burst_q + BW'(1) : '0;
        end
        OWN_B: begin
          if (b_valid && (!a_valid || !burst_max)) gnt_b = 1'b1;
          else if (a_valid)                        gnt_a = 1'b1;
          burst_d = (gnt_b && a_valid) ? burst_q + BW'(1) : '0;
        end
        default: begin
          // Tie goes to the side that did not win last.
          if (a_valid && b_valid) begin
            if (last_q == SRC_B) gnt_a = 1'b1;
            else                 gnt_b = 1'b1;
          end else if (a_valid) begin
            gnt_a = 1'b1;
          end else if (b_valid) begin
            gnt_b = 1'b1;
          end
          burst_d = '0;
        end
      endcase
      state_d = gnt_a ? OWN_A : (gnt_b ? OWN_B : IDLE);
    end
  end

  assign a_ready = gnt_a;
  assign b_ready = gnt_b;
  assign sel     = gnt_b ? SRC_B : SRC_A;

  arb_data_mux #(.WIDTH(WIDTH)) u_mux (
    .sel (sel),
    .a   (a_data),
    .b   (b_data),
    .y   (mux_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      burst_q   <= '0;
      last_q    <= SRC_B;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 1'b0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      if (gnt_a || gnt_b) begin
        last_q   <= sel;
        out_data <= mux_y;
        out_src  <= sel;
      end
      if (load) out_valid <= gnt_a || gnt_b;
    end
  end

`ifdef MUX_RR_ARBITER_STATS_EN
  logic [CNT_W-1:0] cnt_a_q, cnt_b_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      if (gnt_a && cnt_a_q != '1) cnt_a_q <= cnt_a_q + CNT_W'(1);
      if (gnt_b && cnt_b_q != '1) cnt_b_q <= cnt_b_q + CNT_W'(1);
    end
  end

  assign cnt_a = cnt_a_q;
  assign cnt_b = cnt_b_q;
`else
  assign cnt_a = '0;
  assign cnt_b = '0;
`endif

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter (BURST=4, CNT_W=4).
// Counter expectations follow MUX_RR_ARBITER_STATS_EN.
module tb_mux_rr_arbiter;

  localparam int WIDTH = 2;
  localparam int CNT_W = 4;
`ifdef MUX_RR_ARBITER_STATS_EN
  localparam logic [CNT_W-1:0] EXP_CNT = 4'hF;
`else
  localparam logic [CNT_W-1:0] EXP_CNT = 4'h0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             a_valid, b_valid;
  logic [WIDTH-1:0] a_data, b_data;
  logic             a_ready, b_ready;
  logic             out_valid, out_src, out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] cnt_a, cnt_b;

  int checks = 0;
  int errors = 0;

  mux_rr_arbiter #(.WIDTH(WIDTH), .BURST(4), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready),
    .cnt_a     (cnt_a),
    .cnt_b     (cnt_b)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_valid = 1'b1;
    b_valid = 1'b1;
    a_data = 2'b01;
    b_data = 2'b11;
    out_ready = 1'b1;
    repeat (2) step();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 2'b00 || out_src !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: got v=%b d=%b s=%b want 0 00 0",
               out_valid, out_data, out_src);
    end
    checks++;
    if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got a=%b b=%b want 0 0", a_ready, b_ready);
    end
    checks++;
    if (cnt_a !== 4'h0 || cnt_b !== 4'h0) begin
      errors++;
      $display("FAIL reset_cnt: got %h %h want 0 0", cnt_a, cnt_b);
    end
  endtask

  task automatic test_lone_a();
    rst = 1'b0;
    a_valid = 1'b1;
    a_data = 2'b10;
    b_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      checks++;
      if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
        errors++;
        $display("FAIL lone_ready[%0d]: got a=%b b=%b want 1 0",
                 i, a_ready, b_ready);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 2'b10 || out_src !== 1'b0) begin
        errors++;
        $display("FAIL lone_out[%0d]: got v=%b d=%b s=%b want 1 10 0",
                 i, out_valid, out_data, out_src);
      end
    end
    checks++;
    if (cnt_a !== EXP_CNT || cnt_b !== 4'h0) begin
      errors++;
      $display("FAIL stats_sat: got a=%h b=%h want %h 0", cnt_a, cnt_b, EXP_CNT);
    end
    a_valid = 1'b0;
    #1;
    checks++;
    if (a_ready !== 1'b0) begin
      errors++;
      $display("FAIL lone_drop_ready: got %b want 0", a_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_valid: got %b want 0", out_valid);
    end
  endtask

  task automatic test_contention();
    logic exp_b;
    rst = 1'b1;
    step();
    rst = 1'b0;
    a_valid = 1'b1;
    a_data = 2'b01;
    b_valid = 1'b1;
    b_data = 2'b11;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_b = ((i / 4) % 2) == 1;
      #1;
      checks++;
      if (a_ready !== !exp_b || b_ready !== exp_b) begin
        errors++;
        $display("FAIL rr_grant[%0d]: got a=%b b=%b want a=%b b=%b",
                 i, a_ready, b_ready, !exp_b, exp_b);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || out_src !== exp_b ||
          out_data !== (exp_b ? 2'b11 : 2'b01)) begin
        errors++;
        $display("FAIL rr_out[%0d]: got v=%b s=%b d=%b want s=%b",
                 i, out_valid, out_src, out_data, exp_b);
      end
    end
  endtask

  task automatic test_backpressure();
    b_valid = 1'b0;
    a_data = 2'b10;
    #1;
    checks++;
    if (a_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_pre_ready: got %b want 1", a_ready);
    end
    step();
    out_ready = 1'b0;
    a_data = 2'b01;
    b_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_ready[%0d]: got a=%b b=%b want 0 0",
                 i, a_ready, b_ready);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 2'b10 || out_src !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b d=%b s=%b want 1 10 0",
                 i, out_valid, out_data, out_src);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got a=%b b=%b want 1 0", a_ready, b_ready);
    end
    step();
    checks++;
    if (out_data !== 2'b01 || out_src !== 1'b0) begin
      errors++;
      $display("FAIL bp_resume: got d=%b s=%b want 01 0", out_data, out_src);
    end
  endtask

  task automatic test_owner_drop();
    logic exp_b;
    a_valid = 1'b0;
    b_valid = 1'b1;
    b_data = 2'b11;
    #1;
    checks++;
    if (b_ready !== 1'b1 || a_ready !== 1'b0) begin
      errors++;
      $display("FAIL drop_grant: got a=%b b=%b want 0 1", a_ready, b_ready);
    end
    step();
    checks++;
    if (out_src !== 1'b1 || out_data !== 2'b11) begin
      errors++;
      $display("FAIL drop_out: got s=%b d=%b want 1 11", out_src, out_data);
    end
    a_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_b = (i < 3);
      #1;
      checks++;
      if (b_ready !== exp_b || a_ready !== !exp_b) begin
        errors++;
        $display("FAIL drop_burst[%0d]: got a=%b b=%b want b=%b",
                 i, a_ready, b_ready, exp_b);
      end
      step();
    end
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_ready: got a=%b b=%b want 0 0", a_ready, b_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 2'b00 || cnt_a !== 4'h0) begin
      errors++;
      $display("FAIL midrst_out: got v=%b d=%b c=%h want 0 00 0",
               out_valid, out_data, cnt_a);
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lone_a();
    test_contention();
    test_backpressure();
    test_owner_drop();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
